memory_arbiter: RTL and testbench

//  Shares the single 128-bit-block main memory between instruction_cache and data cache miss paths.

---
 rtl/memory_arbiter.sv | 145 ++++++++++++++
 tb/tb_memory_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Arbitrates one 128-bit memory block transfer at a time between the I-cache and D-cache miss paths.
// Grant-to-grant is at least 4 cycles. A requester stalls on busywait until its one-cycle ack, and the D side wins unless I has been starved.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         icache_read,
    input  logic [27:0]  icache_address,
    output logic [127:0] icache_readinst,
    output logic         icache_busywait,
    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [27:0]  dcache_address,
    input  logic [127:0] dcache_writedata,
    output logic [127:0] dcache_readdata,
    output logic         dcache_busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t         state_q, state_d;
    logic           owner_d_q, owner_d_d;
    logic           mem_read_q, mem_read_d;
    logic           mem_write_q, mem_write_d;
    logic [27:0]    mem_address_q, mem_address_d;
    logic [127:0]   mem_writedata_q, mem_writedata_d;
    logic [127:0]   irdata_q, irdata_d;
    logic [127:0]   drdata_q, drdata_d;
    logic           ack_i_q, ack_i_d;
    logic           ack_d_q, ack_d_d;
    logic [CW-1:0]  starve_cnt_q, starve_cnt_d;

    logic req_i, req_d, starved, grant_i;

    assign req_i   = icache_read;
    assign req_d   = dcache_read | dcache_write;
    assign starved = (starve_cnt_q == CW'(STARVE_LIMIT));
    assign grant_i = req_i & (starved | ~req_d);

    always_comb begin
        state_d         = state_q;
        owner_d_d       = owner_d_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        irdata_d        = irdata_q;
        drdata_d        = drdata_q;
        ack_i_d         = 1'b0;
        ack_d_d         = 1'b0;
        starve_cnt_d    = starve_cnt_q;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    owner_d_d     = 1'b0;
                    mem_read_d    = 1'b1;
                    mem_write_d   = 1'b0;
                    mem_address_d = icache_address;
                    starve_cnt_d  = '0;
                    state_d       = ISSUE;
                end else if (req_d) begin
                    owner_d_d     = 1'b1;
                    mem_address_d = dcache_address;
                    // A write-back takes precedence over a read raised alongside it
                    if (dcache_write) begin
                        mem_read_d      = 1'b0;
                        mem_write_d     = 1'b1;
                        mem_writedata_d = dcache_writedata;
                    end else begin
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end
                    if (req_i && !starved)
                        starve_cnt_d = starve_cnt_q + CW'(1);
                    state_d = ISSUE;
                end
            end
            // Memory raises busywait only after seeing the strobe, so skip one sample
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (!mem_busywait) begin
                    if (mem_read_q) begin
                        if (owner_d_q) drdata_d = mem_readdata;
                        else           irdata_d = mem_readdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    ack_i_d     = ~owner_d_q;
                    ack_d_d     = owner_d_q;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= IDLE;
            owner_d_q       <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            irdata_q        <= '0;
            drdata_q        <= '0;
            ack_i_q         <= 1'b0;
            ack_d_q         <= 1'b0;
            starve_cnt_q    <= '0;
        end else begin
            state_q         <= state_d;
            owner_d_q       <= owner_d_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            irdata_q        <= irdata_d;
            drdata_q        <= drdata_d;
            ack_i_q         <= ack_i_d;
            ack_d_q         <= ack_d_d;
            starve_cnt_q    <= starve_cnt_d;
        end
    end

    assign icache_readinst = irdata_q;
    assign dcache_readdata = drdata_q;
    assign icache_busywait = req_i & ~ack_i_q;
    assign dcache_busywait = req_d & ~ack_d_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_writedata   = mem_writedata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a latency-programmable memory model plus a grant-order log.
module tb_memory_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         icache_read = 1'b0;
    logic [27:0]  icache_address = '0;
    logic [127:0] icache_readinst;
    logic         icache_busywait;
    logic         dcache_read = 1'b0;
    logic         dcache_write = 1'b0;
    logic [27:0]  dcache_address = '0;
    logic [127:0] dcache_writedata = '0;
    logic [127:0] dcache_readdata;
    logic         dcache_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b0;

    int checks = 0;
    int errors = 0;
    int mem_lat = 5;
    int mem_cnt = 0;
    logic prev_strb = 1'b0;
    logic [27:0] grants[$];

    memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_readinst(icache_readinst), .icache_busywait(icache_busywait),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_writedata(dcache_writedata),
        .dcache_readdata(dcache_readdata), .dcache_busywait(dcache_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    // Memory holds busywait for mem_lat falling edges after a strobe appears
    always @(negedge clock) begin
        if (mem_read === 1'b1 || mem_write === 1'b1) begin
            if (mem_cnt < mem_lat) begin
                mem_busywait = 1'b1;
                mem_cnt++;
            end else begin
                mem_busywait = 1'b0;
            end
        end else begin
            mem_busywait = 1'b0;
            mem_cnt = 0;
        end
        if ((mem_read === 1'b1 || mem_write === 1'b1) && !prev_strb)
            grants.push_back(mem_address);
        prev_strb = (mem_read === 1'b1 || mem_write === 1'b1);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_bw_low(input bit is_d, input string tag);
        int n = 0;
        while ((is_d ? dcache_busywait : icache_busywait) !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check(tag, (n < 100), 1);
    endtask

    task automatic wait_strobe(input bit level, input string tag);
        int n = 0;
        while ((mem_read | mem_write) !== level && n < 100) begin
            tick();
            n++;
        end
        check(tag, (n < 100), 1);
    endtask

    initial begin
        int hi;
        int n;
        bit d_hit;
        bit ibad;
        bit chk5;
        logic [27:0] exp_order[6];

        // Reset state
        reset = 1'b0;
        tick(); tick(); tick();
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_writedata", mem_writedata, 0);
        check("rst_readinst", icache_readinst, 0);
        check("rst_readdata", dcache_readdata, 0);
        check("rst_ibusy", icache_busywait, 0);
        check("rst_dbusy", dcache_busywait, 0);
        reset = 1'b1;
        tick();

        // 1: lone I read, 5-cycle memory
        mem_lat = 5;
        icache_address = 28'h0000010;
        mem_readdata = {16{8'hA5}};
        icache_read = 1'b1;
        #1;
        check("t1_ibusy_req", icache_busywait, 1);
        tick();
        check("t1_mem_read", mem_read, 1);
        check("t1_mem_addr", mem_address, 28'h0000010);
        hi = 0; d_hit = 0; n = 0;
        while (icache_busywait && n < 100) begin
            if (mem_read) hi++;
            if (dcache_busywait) d_hit = 1;
            tick();
            n++;
        end
        check("t1_timeout", (n < 100), 1);
        check("t1_strobe_cycles", hi, 6);
        check("t1_readinst", icache_readinst, {16{8'hA5}});
        check("t1_mem_read_clr", mem_read, 0);
        check("t1_dbusy_untouched", d_hit, 0);
        tick();
        check("t1_ibusy_one_cycle", icache_busywait, 1);
        icache_read = 1'b0;
        tick();
        check("t1_no_regrant", mem_read, 0);

        // 2: I read and D write on the same edge
        icache_address = 28'h0000020;
        dcache_address = 28'h0000030;
        dcache_writedata = {4{32'hDEADBEEF}};
        mem_readdata = {8{16'h1234}};
        icache_read = 1'b1;
        dcache_write = 1'b1;
        tick();
        check("t2_mem_write", mem_write, 1);
        check("t2_mem_read", mem_read, 0);
        check("t2_mem_addr", mem_address, 28'h0000030);
        check("t2_mem_wdata", mem_writedata, {4{32'hDEADBEEF}});
        ibad = 0; n = 0;
        while (dcache_busywait && n < 100) begin
            if (!icache_busywait) ibad = 1;
            tick();
            n++;
        end
        check("t2_timeout", (n < 100), 1);
        check("t2_ibusy_held", ibad | !icache_busywait, 0);
        check("t2_dcache_readdata", dcache_readdata, 0);
        dcache_write = 1'b0;
        wait_strobe(1'b1, "t2_i_grant_timeout");
        check("t2_i_mem_read", mem_read, 1);
        check("t2_i_mem_addr", mem_address, 28'h0000020);
        wait_bw_low(1'b0, "t2_i_timeout");
        check("t2_readinst", icache_readinst, {8{16'h1234}});
        icache_read = 1'b0;
        tick();

        // 3: starvation guard, D back-to-back with I pending
        mem_lat = 1;
        grants.delete();
        icache_address = 28'h0000111;
        dcache_address = 28'h0000222;
        icache_read = 1'b1;
        dcache_read = 1'b1;
        n = 0; chk5 = 0;
        while (grants.size() < 6 && n < 300) begin
            tick();
            n++;
            if (grants.size() == 5 && !chk5) begin
                chk5 = 1;
                check("t3_starve_after_i", dut.starve_cnt_q, 0);
            end
        end
        check("t3_timeout", (n < 300), 1);
        check("t3_starve_after_d", dut.starve_cnt_q, 1);
        icache_read = 1'b0;
        dcache_read = 1'b0;
        wait_strobe(1'b0, "t3_drain_timeout");
        tick(); tick(); tick();
        exp_order = '{28'h0000222, 28'h0000222, 28'h0000222, 28'h0000222,
                      28'h0000111, 28'h0000222};
        check("t3_grant_count", grants.size(), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            check($sformatf("t3_grant%0d", i), grants[i], exp_order[i]);

        // 4: reset during WAIT of a D read
        mem_lat = 5;
        dcache_address = 28'h0000555;
        mem_readdata = {4{32'hCAFEF00D}};
        dcache_read = 1'b1;
        tick();
        tick();
        check("t4_in_wait", dut.state_q, 2);
        reset = 1'b0;
        tick();
        check("t4_mem_read_drop", mem_read, 0);
        check("t4_state_idle", dut.state_q, 0);
        check("t4_no_ack", dcache_busywait, 1);
        check("t4_readdata_rst", dcache_readdata, 0);
        check("t4_readinst_rst", icache_readinst, 0);
        reset = 1'b1;
        tick();
        check("t4_fresh_read", mem_read, 1);
        check("t4_fresh_addr", mem_address, 28'h0000555);
        wait_bw_low(1'b1, "t4_timeout");
        check("t4_readdata", dcache_readdata, {4{32'hCAFEF00D}});
        dcache_read = 1'b0;
        tick();

        // 5: D read and write both high is a write only
        dcache_address = 28'h0000666;
        dcache_writedata = {2{64'h0123456789ABCDEF}};
        mem_readdata = {16{8'h5A}};
        dcache_read = 1'b1;
        dcache_write = 1'b1;
        tick();
        check("t5_mem_write", mem_write, 1);
        check("t5_mem_read", mem_read, 0);
        check("t5_mem_wdata", mem_writedata, {2{64'h0123456789ABCDEF}});
        wait_bw_low(1'b1, "t5_timeout");
        check("t5_readdata_kept", dcache_readdata, {4{32'hCAFEF00D}});
        dcache_read = 1'b0;
        dcache_write = 1'b0;
        tick();

        // 6: D withdraws mid-WAIT, transfer still completes, then I served
        grants.delete();
        mem_readdata = {8{16'hBEEF}};
        dcache_address = 28'h0000333;
        icache_address = 28'h0000444;
        dcache_read = 1'b1;
        icache_read = 1'b1;
        tick();
        check("t6_d_first", mem_address, 28'h0000333);
        tick();
        tick();
        dcache_read = 1'b0;
        #1;
        check("t6_dbusy_dropped", dcache_busywait, 0);
        check("t6_still_reading", mem_read, 1);
        wait_strobe(1'b0, "t6_complete_timeout");
        check("t6_state_done", dut.state_q, 3);
        check("t6_readdata", dcache_readdata, {8{16'hBEEF}});
        mem_readdata = {16{8'h77}};
        wait_strobe(1'b1, "t6_i_grant_timeout");
        check("t6_i_addr", mem_address, 28'h0000444);
        check("t6_i_mem_read", mem_read, 1);
        wait_bw_low(1'b0, "t6_i_timeout");
        check("t6_readinst", icache_readinst, {16{8'h77}});
        icache_read = 1'b0;
        tick();
        check("t6_grant_count", grants.size(), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
